fifo_burst_arbiter: RTL and testbench
=====================================

# fifo_burst_arbiter

Round-robin burst arbiter sharing the single write port of a 16-bit write-side FIFO among NUM_REQ stream requesters. Each winner keeps the port for one burst: until its last beat, MAX_BURST beats, or a stall timeout. FIFO back-pressure (`fifo_full`) pauses bursts in place. The block sits directly in front of the FIFO write side and runs on that side's single clock.

## Interface
- `DATA_WIDTH`, 16: word width; equals the FIFO width.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `MAX_BURST`, 8: beat cap per grant, ≥1.
- `STALL_LIMIT`, 16: consecutive idle granted cycles before forced release, ≥1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req_valid` input NUM_REQ: per-requester word valid.
- `req_data` input NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` input NUM_REQ: marks the final beat of the requester's packet.
- `req_ready` output NUM_REQ: one-hot or zero; accept strobe to the granted requester.
- `fifo_full` input 1: FIFO full flag.
- `fifo_wen` output 1: FIFO write enable.
- `fifo_din` output DATA_WIDTH: FIFO write data.
- `grant_id` output $clog2(NUM_REQ): current or last granted requester.
- `busy` output 1: high while in XFER.

## Operation
- FSM states are IDLE and XFER.
- **IDLE**
  - If any `req_valid` is set, select the first asserted requester searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Register `grant_id`, clear `beat_cnt` and `stall_cnt`, go to XFER.
  - No transfer happens in IDLE.
- **XFER**
  - `req_ready[grant_id] = ~fifo_full`; all other ready bits are 0.
  - A beat transfers when `req_valid[grant_id] && req_ready[grant_id]`.
  - On a beat: `fifo_wen = 1`, `fifo_din = req_data[grant_id]`, `beat_cnt` increments, `stall_cnt` clears.
  - `fifo_wen` is never asserted without a beat.
  - Cycle with no beat because the granted valid is low: `stall_cnt` increments.
  - Cycle with no beat because `fifo_full` is high: `stall_cnt` holds. Back-pressure never times out.
- **Burst end** (transition to IDLE): any of
  - a beat with `req_last[grant_id]` set;
  - a beat that makes `beat_cnt == MAX_BURST`;
  - `stall_cnt` reaching STALL_LIMIT.
- On burst end, `rr_ptr = (grant_id + 1) mod NUM_REQ`, and `grant_id` holds its value.
- Stall-timeout release drops the partial packet boundary. The requester resumes on its next grant. The arbiter does not track packet framing.
- Widths:
  - `beat_cnt` is $clog2(MAX_BURST+1) bits.
  - `stall_cnt` is $clog2(STALL_LIMIT+1) bits.
  - `rr_ptr` is $clog2(NUM_REQ) bits.
  - Modulo wrap is explicit, so a non-power-of-two NUM_REQ wraps from NUM_REQ-1 to 0.
- Valid and data from non-granted requesters are ignored. They must hold until they see ready.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `beat_cnt` 0, `stall_cnt` 0, `busy` 0, `fifo_wen` 0, `req_ready` all 0, `fifo_din` 0.
- While `rst_n` is low, `fifo_wen` and `req_ready` are forced to 0 combinationally. Reset mid-burst writes nothing in the reset cycle and restarts at IDLE with `rr_ptr` 0.
- Arbitration latency:
  - `req_valid` seen in IDLE at cycle N gives `busy` and grant at N+1.
  - Earliest first beat is cycle N+1.
- Gap between bursts is exactly 1 IDLE cycle.
- Uncontended MAX_BURST-beat burst throughput is MAX_BURST words per MAX_BURST+1 cycles.
- `req_ready`, `fifo_wen` and `fifo_din` are combinational from registered state, `fifo_full` and the granted `req_valid`/`req_data`.
- `fifo_full` rising in the same cycle as a pending beat blocks that beat. No word is lost or duplicated.
- `req_last` and the MAX_BURST cap on the same beat count as a single burst end.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum (IDLE, XFER);
  - default-parameter constants;
  - the index-width helper function.
- Sub-module `rr_picker`: combinational. Takes NUM_REQ `req_valid` and `rr_ptr`; produces `any` and `winner` index. It is reused by future read-side schedulers.
- The top holds the FSM, counters and datapath mux.

## Test plan
1. Single requester: requester 2 sends 3 beats 0xA1..0xA3 with last on the third. Expect grant at +1 cycle, 3 consecutive `fifo_wen` with exactly those words, `rr_ptr` = 3, return to IDLE.
2. Burst cap: requester 0 streams 20 words, never asserting last, all 4 requesters valid continuously.
   - Expect `grant_id` sequence 0,1,2,3,0 with 8 beats each.
   - Expect one idle cycle between grants.
3. Back-pressure: `fifo_full` is held high for 5 cycles mid-burst at beat 3.
   - Expect `req_ready` and `fifo_wen` low for those 5 cycles and no timeout.
   - Burst resumes and completes 8 beats; word order is preserved.
4. Stall timeout: the granted requester drops valid for 16 cycles after beat 2. Expect release after exactly 16 idle cycles and the next grant to the next valid requester.
5. Reset mid-burst: assert `rst_n` low at beat 4. Expect `fifo_wen`=0 that cycle, all outputs at reset values next cycle, and the following grant going to requester 0 first.
6. Non-power-of-two: with NUM_REQ=3 and all requesters valid, expect `grant_id` 0,1,2,0 with correct wrap.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-side burst arbiter.
// Also hosts the index-width helper used by the arbiter and picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_MAX_BURST   = 8;
    localparam int DEF_STALL_LIMIT = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_burst_arbiter_rr_picker.sv
// Round-robin picker: first valid requester at or above rr_ptr, wrapping.
// Purely combinational so read-side schedulers can share it.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic               any,
    output logic [IW-1:0]      winner
);

    localparam int SW = IW + 1;

    logic [SW-1:0] slot;

    // scan from the farthest offset down so the nearest valid wins last
    always_comb begin
        any    = 1'b0;
        winner = '0;
        slot   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            slot = {1'b0, rr_ptr} + SW'(i);
            if (slot >= SW'(NUM_REQ)) begin
                slot = slot - SW'(NUM_REQ);
            end
            if (req_valid[slot[IW-1:0]]) begin
                any    = 1'b1;
                winner = slot[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst arbiter feeding the single write port of a FIFO.
// A grant lasts until last beat, the beat cap, or a stall timeout.
module fifo_burst_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    arb_state_t state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] stall_q, stall_d;

    logic pick_any;
    logic [IW-1:0] pick_idx;

    logic g_valid;
    logic g_last;
    logic [DATA_WIDTH-1:0] g_data;

    logic xfer;
    logic port_open;
    logic beat;
    logic stall;
    logic cap_hit;
    logic stall_hit;
    logic [BW-1:0] beat_inc;
    logic [SW-1:0] stall_inc;
    logic [IW-1:0] next_ptr;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr_q),
        .any      (pick_any),
        .winner   (pick_idx)
    );

    // view of the currently granted requester only
    always_comb begin
        g_valid = req_valid[grant_q];
        g_last  = req_last[grant_q];
        g_data  = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    end

    // handshake, FIFO write port and burst-end conditions
    always_comb begin
        xfer      = (state_q == XFER);
        port_open = xfer && !fifo_full && rst_n;
        beat      = port_open && g_valid;
        stall     = xfer && !fifo_full && !g_valid;
        beat_inc  = beat_q + BW'(1);
        stall_inc = stall_q + SW'(1);
        cap_hit   = (beat_inc == BW'(MAX_BURST));
        stall_hit = (stall_inc == SW'(STALL_LIMIT));
        next_ptr  = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = port_open && (grant_q == IW'(i));
        end
        fifo_wen = beat;
        fifo_din = beat ? g_data : '0;
        grant_id = grant_q;
        busy     = xfer;
    end

    // next-state: arbitrate in IDLE, count beats/stalls in XFER
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        stall_d  = stall_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat) begin
                    beat_d  = beat_inc;
                    stall_d = '0;
                    if (g_last || cap_hit) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (stall) begin
                    stall_d = stall_inc;
                    if (stall_hit) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and counter registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            beat_q   <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            beat_q   <= beat_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Self-checking bench for fifo_burst_arbiter with a behavioural model.
// A second 3-requester instance covers the non-power-of-two wrap.
module tb_fifo_burst_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wen;
    logic [15:0] fifo_din;
    logic [1:0]  grant_id;
    logic        busy;

    logic [2:0]  v3;
    logic [47:0] d3;
    logic [2:0]  l3;
    logic [2:0]  r3;
    logic        full3;
    logic        wen3;
    logic [15:0] din3;
    logic [1:0]  gid3;
    logic        busy3;

    fifo_burst_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wen(fifo_wen), .fifo_din(fifo_din),
        .grant_id(grant_id), .busy(busy)
    );

    fifo_burst_arbiter #(.NUM_REQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v3), .req_data(d3), .req_last(l3),
        .req_ready(r3), .fifo_full(full3),
        .fifo_wen(wen3), .fifo_din(din3),
        .grant_id(gid3), .busy(busy3)
    );

    wire [23:0] actv = {busy, grant_id, req_ready, fifo_wen, fifo_din};

    typedef struct {
        int          cyc;
        int          gid;
        logic [15:0] data;
    } wr_t;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [3:0] en;
    logic [16:0] srcq [4][$];
    wr_t wlog[$];

    bit m_busy;
    int m_gid, m_ptr, m_beats, m_idle;

    function automatic logic [23:0] expv();
        logic [3:0] rdy;
        logic wen;
        logic [15:0] din;
        rdy = '0;
        wen = 1'b0;
        din = '0;
        if (rst_n && m_busy && !fifo_full) begin
            rdy[m_gid] = 1'b1;
            if (req_valid[m_gid]) begin
                wen = 1'b1;
                din = req_data[m_gid*16 +: 16];
            end
        end
        return {m_busy, 2'(m_gid), rdy, wen, din};
    endfunction

    task automatic model_update();
        bit found;
        int k;
        if (!rst_n) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0; m_idle = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int j = 0; j < 4; j++) begin
                k = (m_ptr + j) % 4;
                if (!found && req_valid[k]) begin
                    found = 1;
                    m_gid = k;
                end
            end
            if (found) begin
                m_busy = 1; m_beats = 0; m_idle = 0;
            end
        end else if (!fifo_full && req_valid[m_gid]) begin
            m_beats++;
            m_idle = 0;
            if (req_last[m_gid] || m_beats == 8) begin
                m_busy = 0;
                m_ptr = (m_gid + 1) % 4;
            end
        end else if (!fifo_full) begin
            m_idle++;
            if (m_idle == 16) begin
                m_busy = 0;
                m_ptr = (m_gid + 1) % 4;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (en[i] && srcq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                {req_last[i], req_data[i*16 +: 16]} = srcq[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i] = 1'b0;
                req_data[i*16 +: 16] = '0;
            end
        end
    endtask

    task automatic tick();
        logic [3:0] hs;
        hs = req_ready & req_valid;
        if (fifo_wen) wlog.push_back('{cyc, int'(grant_id), fifo_din});
        model_update();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        #1;
        drive();
    endtask

    task automatic flush();
        rst_n = 1'b0;
        en = '0;
        fifo_full = 1'b0;
        v3 = '0;
        for (int i = 0; i < 4; i++) srcq[i].delete();
        drive();
        tick();
        tick();
        wlog.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        flush();
        rst_n = 1'b0;
        srcq[1].push_back({1'b1, 16'h0B0B});
        en = 4'hF;
        for (int c = 0; c < 3; c++) begin
            drive(); #1;
            if (actv !== 24'h0 || actv !== expv()) begin
                n_fail++;
                $display("FAIL reset_state got %h want %h", actv, 24'h0);
            end
            n_vec++;
            tick();
        end
        rst_n = 1'b1;
        drive(); #1;
        tick();
        drive(); #1;
        if (busy !== 1'b1 || grant_id !== 2'd1 || actv !== expv()) begin
            n_fail++;
            $display("FAIL reset_exit got busy=%b gid=%0d want busy=1 gid=1", busy, grant_id);
        end
        n_vec++;
    endtask

    task automatic test_single();
        int c0;
        flush();
        srcq[2].push_back({1'b0, 16'h00A1});
        srcq[2].push_back({1'b0, 16'h00A2});
        srcq[2].push_back({1'b1, 16'h00A3});
        en = 4'hF;
        c0 = cyc;
        for (int c = 0; c < 8; c++) begin
            drive(); #1;
            if (actv !== expv()) begin
                n_fail++;
                $display("FAIL single cyc=%0d got %h want %h", cyc, actv, expv());
            end
            n_vec++;
            tick();
        end
        if (wlog.size() != 3) begin
            n_fail++;
            $display("FAIL single_count got %0d want 3", wlog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wlog[i].gid != 2 || wlog[i].data !== 16'(16'hA1 + i) || wlog[i].cyc != c0 + 1 + i) begin
                    n_fail++;
                    $display("FAIL single_word%0d got g%0d %h @%0d want g2 %h @%0d", i, wlog[i].gid, wlog[i].data, wlog[i].cyc, 16'(16'hA1 + i), c0 + 1 + i);
                end
                n_vec++;
            end
        end
        srcq[0].push_back({1'b1, 16'h0C00});
        srcq[3].push_back({1'b1, 16'h0C03});
        drive(); #1;
        tick();
        drive(); #1;
        if (busy !== 1'b1 || grant_id !== 2'd3 || actv !== expv()) begin
            n_fail++;
            $display("FAIL single_rrptr got gid=%0d busy=%b want gid=3 busy=1", grant_id, busy);
        end
        n_vec++;
        repeat (4) tick();
    endtask

    task automatic test_burst_cap();
        int bg[$], bl[$], bs[$], be[$];
        flush();
        for (int k = 0; k < 20; k++) srcq[0].push_back({1'b0, 16'(k)});
        for (int i = 1; i < 4; i++) begin
            for (int k = 0; k < 10; k++) srcq[i].push_back({1'b0, 16'(i * 16'h1000 + k)});
        end
        en = 4'hF;
        for (int c = 0; c < 60; c++) begin
            drive(); #1;
            if (actv !== expv()) begin
                n_fail++;
                $display("FAIL burst_cap cyc=%0d got %h want %h", cyc, actv, expv());
            end
            n_vec++;
            tick();
        end
        foreach (wlog[i]) begin
            if (i == 0 || wlog[i].gid != bg[$] || wlog[i].cyc != be[$] + 1) begin
                bg.push_back(wlog[i].gid);
                bl.push_back(0);
                bs.push_back(wlog[i].cyc);
                be.push_back(wlog[i].cyc);
            end
            bl[bl.size()-1]++;
            be[be.size()-1] = wlog[i].cyc;
        end
        if (bg.size() < 5) begin
            n_fail++;
            $display("FAIL burst_cap_count got %0d bursts want >=5", bg.size());
        end else begin
            for (int b = 0; b < 5; b++) begin
                if (bg[b] != b % 4 || bl[b] != 8) begin
                    n_fail++;
                    $display("FAIL burst_cap_b%0d got g%0d len%0d want g%0d len8", b, bg[b], bl[b], b % 4);
                end
                n_vec++;
                if (b < 4 && bs[b+1] - be[b] != 2) begin
                    n_fail++;
                    $display("FAIL burst_gap_b%0d got %0d want 2", b, bs[b+1] - be[b]);
                end
                if (b < 4) n_vec++;
            end
        end
    endtask

    task automatic test_backpressure();
        int bp_left;
        bit trig;
        flush();
        for (int k = 0; k < 8; k++) srcq[1].push_back({k == 7, 16'(16'hB0 + k)});
        en = 4'hF;
        bp_left = 0;
        trig = 0;
        for (int c = 0; c < 30; c++) begin
            if (!trig && m_busy && m_beats == 3) begin
                trig = 1;
                bp_left = 5;
            end
            fifo_full = (bp_left > 0);
            drive(); #1;
            if (actv !== expv()) begin
                n_fail++;
                $display("FAIL backpressure cyc=%0d got %h want %h", cyc, actv, expv());
            end
            n_vec++;
            if (bp_left > 0) begin
                if (req_ready !== 4'h0 || fifo_wen !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc=%0d got rdy=%b wen=%b busy=%b want 0000 0 1", cyc, req_ready, fifo_wen, busy);
                end
                n_vec++;
                bp_left--;
            end
            tick();
        end
        fifo_full = 1'b0;
        if (wlog.size() != 8) begin
            n_fail++;
            $display("FAIL bp_count got %0d want 8", wlog.size());
        end else begin
            foreach (wlog[i]) begin
                if (wlog[i].gid != 1 || wlog[i].data !== 16'(16'hB0 + i)) begin
                    n_fail++;
                    $display("FAIL bp_order%0d got g%0d %h want g1 %h", i, wlog[i].gid, wlog[i].data, 16'(16'hB0 + i));
                end
                n_vec++;
            end
        end
    endtask

    task automatic test_stall();
        bit dropped;
        bit saw1;
        int stall_cyc;
        flush();
        for (int k = 0; k < 5; k++) srcq[0].push_back({k == 4, 16'(16'hD0 + k)});
        srcq[1].push_back({1'b0, 16'h00E0});
        srcq[1].push_back({1'b1, 16'h00E1});
        en = 4'hF;
        dropped = 0;
        saw1 = 0;
        stall_cyc = 0;
        for (int c = 0; c < 40; c++) begin
            if (!dropped && m_busy && m_gid == 0 && m_beats == 2) begin
                dropped = 1;
                en[0] = 1'b0;
            end
            drive(); #1;
            if (actv !== expv()) begin
                n_fail++;
                $display("FAIL stall cyc=%0d got %h want %h", cyc, actv, expv());
            end
            n_vec++;
            if (dropped && busy && grant_id == 2'd0) stall_cyc++;
            if (busy && grant_id == 2'd1) saw1 = 1;
            tick();
        end
        if (stall_cyc != 16 || !saw1) begin
            n_fail++;
            $display("FAIL stall_release got %0d idle cycles next=%0b want 16 next=1", stall_cyc, saw1);
        end
        n_vec++;
    endtask

    task automatic test_reset_mid();
        bit hit;
        flush();
        for (int k = 0; k < 8; k++) srcq[3].push_back({1'b0, 16'(16'hF0 + k)});
        for (int k = 0; k < 3; k++) srcq[0].push_back({k == 2, 16'(16'h50 + k)});
        en = 4'b1000;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            drive(); #1;
            if (m_busy && m_beats == 4) hit = 1;
            else tick();
        end
        if (!hit) begin
            n_fail++;
            $display("FAIL rstmid_timeout got no beat 4 want beat 4");
        end
        n_vec++;
        rst_n = 1'b0;
        en = 4'b1001;
        drive(); #1;
        if (fifo_wen !== 1'b0 || req_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL rstmid_wen got wen=%b rdy=%b want 0 0000", fifo_wen, req_ready);
        end
        n_vec++;
        tick();
        rst_n = 1'b1;
        drive(); #1;
        if (actv !== 24'h0) begin
            n_fail++;
            $display("FAIL rstmid_state got %h want %h", actv, 24'h0);
        end
        n_vec++;
        tick();
        drive(); #1;
        if (busy !== 1'b1 || grant_id !== 2'd0 || actv !== expv()) begin
            n_fail++;
            $display("FAIL rstmid_regrant got gid=%0d busy=%b want gid=0 busy=1", grant_id, busy);
        end
        n_vec++;
    endtask

    task automatic test_random();
        int n;
        flush();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (srcq[i].size() == 0 && $urandom_range(0, 9) == 0) begin
                    n = $urandom_range(1, 12);
                    for (int k = 0; k < n; k++) begin
                        srcq[i].push_back({(k == n - 1) && ($urandom_range(0, 1) == 1), 16'($urandom)});
                    end
                end
                en[i] = ($urandom_range(0, 7) != 0);
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            drive(); #1;
            if (actv !== expv()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got %h want %h", cyc, actv, expv());
            end
            n_vec++;
            tick();
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_nonpow2();
        int ng;
        int bc;
        bit prev_b;
        flush();
        d3 = {16'h3333, 16'h2222, 16'h1111};
        l3 = '0;
        full3 = 1'b0;
        v3 = 3'b111;
        ng = 0;
        bc = 0;
        prev_b = 0;
        for (int c = 0; c < 60; c++) begin
            drive(); #1;
            if (busy3 && !prev_b) begin
                if (ng > 0 && ng <= 4) begin
                    if (bc != 8) begin
                        n_fail++;
                        $display("FAIL np2_len%0d got %0d want 8", ng - 1, bc);
                    end
                    n_vec++;
                end
                if (ng < 4) begin
                    if (gid3 !== 2'(ng % 3)) begin
                        n_fail++;
                        $display("FAIL np2_grant%0d got %0d want %0d", ng, gid3, ng % 3);
                    end
                    n_vec++;
                end
                ng++;
                bc = 0;
            end
            if (wen3) bc++;
            prev_b = busy3;
            tick();
        end
        if (ng < 4) begin
            n_fail++;
            $display("FAIL np2_timeout got %0d grants want 4", ng);
        end
        n_vec++;
        v3 = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        fifo_full = 1'b0;
        en = '0;
        v3 = '0;
        d3 = '0;
        l3 = '0;
        full3 = 1'b0;
        m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0; m_idle = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_burst_cap();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_random();
        test_nonpow2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
